// File: rtl/l2_cache_update_queue.sv
// L2 pipeline final stage: merges store data into the line, drives the cache
// write port and queues responses in a small FIFO drained over valid/ready.
`ifndef L2_WAYS
`define L2_WAYS 8
`endif
`ifndef L2_SETS
`define L2_SETS 256
`endif

package l2_cache_update_queue_pkg;
  localparam int CACHE_LINE_BYTES = 64;
  localparam int CACHE_LINE_BITS  = CACHE_LINE_BYTES * 8;

  typedef logic [CACHE_LINE_BITS-1:0] cache_line_data_t;
  typedef logic [3:0]  core_id_t;
  typedef logic [3:0]  l1_miss_id_t;
  typedef logic [25:0] l2_addr_t;

  typedef enum logic [3:0] {
    L2REQ_LOAD        = 4'd0,
    L2REQ_STORE       = 4'd1,
    L2REQ_FLUSH       = 4'd2,
    L2REQ_DINVALIDATE = 4'd3,
    L2REQ_IINVALIDATE = 4'd4,
    L2REQ_LOAD_SYNC   = 4'd5,
    L2REQ_STORE_SYNC  = 4'd6,
    L2REQ_LOAD_LOCK   = 4'd7,
    L2REQ_STORE_LOCK  = 4'd8
  } l2req_packet_type_t;

  typedef enum logic [2:0] {
    L2RSP_LOAD_ACK        = 3'd0,
    L2RSP_STORE_ACK       = 3'd1,
    L2RSP_FLUSH_ACK       = 3'd2,
    L2RSP_IINVALIDATE_ACK = 3'd3,
    L2RSP_DINVALIDATE_ACK = 3'd4
  } l2rsp_packet_type_t;

  typedef struct packed {
    core_id_t                     core;
    l1_miss_id_t                  id;
    l2req_packet_type_t           packet_type;
    logic                         cache_type;
    l2_addr_t                     address;
    logic [CACHE_LINE_BYTES-1:0]  store_mask;
    cache_line_data_t             data;
  } l2req_packet_t;

  typedef struct packed {
    logic               status;
    core_id_t           core;
    l1_miss_id_t        id;
    l2rsp_packet_type_t packet_type;
    logic               cache_type;
    l2_addr_t           address;
    cache_line_data_t   data;
  } l2rsp_packet_t;
endpackage

module l2_cache_update_queue
  import l2_cache_update_queue_pkg::*;
#(
  parameter int CACHE_IDX_WIDTH = $clog2(`L2_WAYS * `L2_SETS),
  parameter int RSP_FIFO_DEPTH  = 4,
  parameter int STALL_MARGIN    = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       l2r_request_valid,
  input  l2req_packet_t              l2r_request,
  input  cache_line_data_t           l2r_data,
  input  logic                       l2r_cache_hit,
  input  logic [CACHE_IDX_WIDTH-1:0] l2r_hit_cache_idx,
  input  logic                       l2r_is_l2_fill,
  input  logic                       l2r_is_restarted_flush,
  input  cache_line_data_t           l2r_data_from_memory,
  input  logic                       l2r_store_sync_success,
  input  logic                       l2r_needs_writeback,
  output logic                       l2u_write_en,
  output logic [CACHE_IDX_WIDTH-1:0] l2u_write_addr,
  output cache_line_data_t           l2u_write_data,
  output logic                       l2u_stall,
  output logic                       l2u_overflow,
  output logic                       l2_response_valid,
  output l2rsp_packet_t              l2_response,
  input  logic                       l2_response_ready
);
  localparam int PTR_W = $clog2(RSP_FIFO_DEPTH);
  localparam int CNT_W = $clog2(RSP_FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_COUNT   = CNT_W'(RSP_FIFO_DEPTH);
  localparam logic [CNT_W-1:0] STALL_THRESH = CNT_W'(RSP_FIFO_DEPTH - STALL_MARGIN);

  cache_line_data_t   orig_line;
  logic               update_data, is_store, completed_flush, push, pop, full, push_accept;
  l2rsp_packet_type_t rsp_type;
  l2rsp_packet_t      rsp_d;

  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               stall_q, stall_d, overflow_q, overflow_d;
  l2rsp_packet_t      mem_q [RSP_FIFO_DEPTH];

  always_comb begin
    orig_line   = l2r_is_l2_fill ? l2r_data_from_memory : l2r_data;
    update_data = (l2r_request.packet_type == L2REQ_STORE)
               || (l2r_request.packet_type == L2REQ_STORE_LOCK)
               || (l2r_request.packet_type == L2REQ_STORE_SYNC && l2r_store_sync_success);
    is_store    = (l2r_request.packet_type == L2REQ_STORE)
               || (l2r_request.packet_type == L2REQ_STORE_LOCK)
               || (l2r_request.packet_type == L2REQ_STORE_SYNC);
    for (int unsigned b = 0; b < CACHE_LINE_BYTES; b++)
      l2u_write_data[b*8 +: 8] = (update_data && l2r_request.store_mask[b])
                                 ? l2r_request.data[b*8 +: 8] : orig_line[b*8 +: 8];
    l2u_write_en   = l2r_request_valid && (l2r_is_l2_fill || (l2r_cache_hit && is_store));
    l2u_write_addr = l2r_hit_cache_idx;

    // A dirty flush hit goes back for writeback and answers on its restarted pass.
    completed_flush = (l2r_request.packet_type == L2REQ_FLUSH)
                   && (l2r_is_restarted_flush || !l2r_cache_hit || !l2r_needs_writeback);
    push = l2r_request_valid
        && ((l2r_cache_hit && l2r_request.packet_type != L2REQ_FLUSH)
            || l2r_is_l2_fill || completed_flush
            || l2r_request.packet_type == L2REQ_DINVALIDATE
            || l2r_request.packet_type == L2REQ_IINVALIDATE);

    unique case (l2r_request.packet_type)
      L2REQ_STORE, L2REQ_STORE_SYNC, L2REQ_STORE_LOCK: rsp_type = L2RSP_STORE_ACK;
      L2REQ_FLUSH:       rsp_type = L2RSP_FLUSH_ACK;
      L2REQ_IINVALIDATE: rsp_type = L2RSP_IINVALIDATE_ACK;
      L2REQ_DINVALIDATE: rsp_type = L2RSP_DINVALIDATE_ACK;
      default:           rsp_type = L2RSP_LOAD_ACK;
    endcase

    rsp_d.status      = (l2r_request.packet_type == L2REQ_STORE_SYNC) ? l2r_store_sync_success : 1'b1;
    rsp_d.core        = l2r_request.core;
    rsp_d.id          = l2r_request.id;
    rsp_d.packet_type = rsp_type;
    rsp_d.cache_type  = l2r_request.cache_type;
    rsp_d.address     = l2r_request.address;
    rsp_d.data        = l2u_write_data;
  end

  always_comb begin
    l2_response_valid = (count_q != '0);
    l2_response       = mem_q[rd_ptr_q];
    pop               = l2_response_valid && l2_response_ready;
    full              = (count_q == FULL_COUNT);
    // When full, a push only fits into the slot being vacated by this cycle's pop.
    push_accept       = push && (!full || pop);

    rd_ptr_d   = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    wr_ptr_d   = push_accept ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    count_d    = count_q;
    if (push_accept && !pop)
      count_d = count_q + CNT_W'(1);
    else if (!push_accept && pop)
      count_d = count_q - CNT_W'(1);
    stall_d    = (count_d >= STALL_THRESH);
    overflow_d = overflow_q || (push && !push_accept);

    l2u_stall    = stall_q;
    l2u_overflow = overflow_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      stall_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      stall_q    <= stall_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_accept)
      mem_q[wr_ptr_q] <= rsp_d;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset && l2r_request_valid && l2r_is_restarted_flush) begin
      assert (l2r_request.packet_type == L2REQ_FLUSH)
        else $error("restarted flush with non-flush request type");
      assert (!l2r_is_l2_fill)
        else $error("restarted flush coincides with fill");
    end
  end
`endif
endmodule

// File: tb/tb_l2_cache_update_queue.sv
// Directed bench for l2_cache_update_queue: merge/write port, response mapping,
// FIFO backpressure, overflow, full push+pop and asynchronous reset.
module tb_l2_cache_update_queue;
  import l2_cache_update_queue_pkg::*;

  localparam int IDX_W = 11;

  logic               clk = 1'b0;
  logic               reset;
  logic               l2r_request_valid;
  l2req_packet_t      l2r_request;
  cache_line_data_t   l2r_data;
  logic               l2r_cache_hit;
  logic [IDX_W-1:0]   l2r_hit_cache_idx;
  logic               l2r_is_l2_fill;
  logic               l2r_is_restarted_flush;
  cache_line_data_t   l2r_data_from_memory;
  logic               l2r_store_sync_success;
  logic               l2r_needs_writeback;
  logic               l2u_write_en;
  logic [IDX_W-1:0]   l2u_write_addr;
  cache_line_data_t   l2u_write_data;
  logic               l2u_stall;
  logic               l2u_overflow;
  logic               l2_response_valid;
  l2rsp_packet_t      l2_response;
  logic               l2_response_ready;

  int tests = 0;
  int fails = 0;

  l2_cache_update_queue #(
    .CACHE_IDX_WIDTH(IDX_W),
    .RSP_FIFO_DEPTH (4),
    .STALL_MARGIN   (2)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .l2r_request_valid     (l2r_request_valid),
    .l2r_request           (l2r_request),
    .l2r_data              (l2r_data),
    .l2r_cache_hit         (l2r_cache_hit),
    .l2r_hit_cache_idx     (l2r_hit_cache_idx),
    .l2r_is_l2_fill        (l2r_is_l2_fill),
    .l2r_is_restarted_flush(l2r_is_restarted_flush),
    .l2r_data_from_memory  (l2r_data_from_memory),
    .l2r_store_sync_success(l2r_store_sync_success),
    .l2r_needs_writeback   (l2r_needs_writeback),
    .l2u_write_en          (l2u_write_en),
    .l2u_write_addr        (l2u_write_addr),
    .l2u_write_data        (l2u_write_data),
    .l2u_stall             (l2u_stall),
    .l2u_overflow          (l2u_overflow),
    .l2_response_valid     (l2_response_valid),
    .l2_response           (l2_response),
    .l2_response_ready     (l2_response_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [639:0] obs, input logic [639:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic l2req_packet_t mk_req(input l2req_packet_type_t t, input logic [3:0] id);
    l2req_packet_t r;
    r             = '0;
    r.core        = 4'h2;
    r.id          = id;
    r.packet_type = t;
    r.cache_type  = 1'b1;
    r.address     = 26'h0abcd00 + 26'(id);
    return r;
  endfunction

  function automatic l2rsp_packet_t mk_rsp(input l2rsp_packet_type_t t, input logic st,
                                           input logic [3:0] id, input cache_line_data_t d);
    l2rsp_packet_t r;
    r.status      = st;
    r.core        = 4'h2;
    r.id          = id;
    r.packet_type = t;
    r.cache_type  = 1'b1;
    r.address     = 26'h0abcd00 + 26'(id);
    r.data        = d;
    return r;
  endfunction

  task automatic drive(input l2req_packet_type_t t, input logic [3:0] id, input logic hit,
                       input logic fill, input logic rflush, input logic wb, input logic sync);
    l2r_request_valid      = 1'b1;
    l2r_request            = mk_req(t, id);
    l2r_cache_hit          = hit;
    l2r_is_l2_fill         = fill;
    l2r_is_restarted_flush = rflush;
    l2r_needs_writeback    = wb;
    l2r_store_sync_success = sync;
  endtask

  task automatic idle();
    l2r_request_valid      = 1'b0;
    l2r_cache_hit          = 1'b0;
    l2r_is_l2_fill         = 1'b0;
    l2r_is_restarted_flush = 1'b0;
    l2r_needs_writeback    = 1'b0;
    l2r_store_sync_success = 1'b0;
  endtask

  initial begin
    cache_line_data_t pat, mline;
    logic [3:0] exp_ids [3];
    logic       exp_stall [3];
    pat   = {16{32'hDEADBEEF}};
    mline = {8{64'h0123456789ABCDEF}};
    exp_ids   = '{4'd3, 4'd4, 4'd9};
    exp_stall = '{1'b1, 1'b1, 1'b0};

    reset                = 1'b1;
    l2_response_ready    = 1'b1;
    l2r_request          = mk_req(L2REQ_LOAD, 4'd0);
    l2r_data             = '0;
    l2r_data_from_memory = '0;
    l2r_hit_cache_idx    = 11'h5a5;
    idle();
    #3;
    chk("reset_valid", l2_response_valid, 1'b0);
    chk("reset_stall", l2u_stall, 1'b0);
    chk("reset_overflow", l2u_overflow, 1'b0);
    chk("reset_write_en", l2u_write_en, 1'b0);
    #1 reset = 1'b0;
    tick();

    // STORE hit: bytes 0..3 merged, rest from SRAM line (all zero)
    drive(L2REQ_STORE, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    l2r_request.store_mask = 64'h0F;
    l2r_request.data       = 512'hA4A3A2A1;
    #1;
    chk("store_write_en", l2u_write_en, 1'b1);
    chk("store_write_data", l2u_write_data, 512'hA4A3A2A1);
    chk("store_write_addr", l2u_write_addr, 11'h5a5);
    tick();
    idle();
    chk("store_rsp_valid", l2_response_valid, 1'b1);
    chk("store_rsp", l2_response, mk_rsp(L2RSP_STORE_ACK, 1'b1, 4'd1, 512'hA4A3A2A1));
    tick();
    chk("store_popped", l2_response_valid, 1'b0);

    // STORE_SYNC without reservation: write strobe with the line unchanged
    l2r_data = pat;
    drive(L2REQ_STORE_SYNC, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    l2r_request.store_mask = '1;
    l2r_request.data       = {64{8'h55}};
    #1;
    chk("ssync_write_en", l2u_write_en, 1'b1);
    chk("ssync_write_data", l2u_write_data, pat);
    tick();
    idle();
    chk("ssync_rsp", l2_response, mk_rsp(L2RSP_STORE_ACK, 1'b0, 4'd2, pat));
    tick();

    // Fill: memory data replaces the SRAM line
    l2r_data_from_memory = mline;
    drive(L2REQ_LOAD, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("fill_write_en", l2u_write_en, 1'b1);
    chk("fill_write_data", l2u_write_data, mline);
    tick();
    idle();
    chk("fill_rsp", l2_response, mk_rsp(L2RSP_LOAD_ACK, 1'b1, 4'd3, mline));
    tick();

    // Dirty FLUSH hit: no write, no response
    drive(L2REQ_FLUSH, 4'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    chk("flush_dirty_write_en", l2u_write_en, 1'b0);
    tick();
    idle();
    chk("flush_dirty_no_rsp", l2_response_valid, 1'b0);

    // Restarted FLUSH: acknowledged
    drive(L2REQ_FLUSH, 4'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    #1;
    chk("flush_restart_write_en", l2u_write_en, 1'b0);
    tick();
    idle();
    chk("flush_restart_rsp", l2_response, mk_rsp(L2RSP_FLUSH_ACK, 1'b1, 4'd5, pat));
    tick();

    // FLUSH miss: acknowledged
    drive(L2REQ_FLUSH, 4'd6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    idle();
    chk("flush_miss_valid", l2_response_valid, 1'b1);
    chk("flush_miss_type", l2_response.packet_type, L2RSP_FLUSH_ACK);
    tick();

    // DINVALIDATE miss still answers
    drive(L2REQ_DINVALIDATE, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    chk("dinv_type", l2_response.packet_type, L2RSP_DINVALIDATE_ACK);
    tick();
    chk("drained", l2_response_valid, 1'b0);

    // Backpressure: fill the queue with ids 1..4
    l2_response_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      drive(L2REQ_LOAD, 4'(k), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      chk("bp_stall", l2u_stall, (k >= 2));
    end
    idle();
    chk("bp_head1", l2_response.id, 4'd1);
    chk("bp_no_overflow", l2u_overflow, 1'b0);
    drive(L2REQ_LOAD, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    chk("bp_overflow", l2u_overflow, 1'b1);
    chk("bp_head_kept", l2_response.id, 4'd1);

    // Full queue with simultaneous push and pop
    l2_response_ready = 1'b1;
    drive(L2REQ_LOAD, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    chk("fullpp_head2", l2_response.id, 4'd2);
    chk("fullpp_stall", l2u_stall, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("drain_id", l2_response.id, exp_ids[k]);
      chk("drain_stall", l2u_stall, exp_stall[k]);
    end
    tick();
    chk("drain_empty", l2_response_valid, 1'b0);
    chk("overflow_sticky", l2u_overflow, 1'b1);

    // Asynchronous reset with 3 queued entries
    l2_response_ready = 1'b0;
    for (int k = 10; k <= 12; k++) begin
      drive(L2REQ_LOAD, 4'(k), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    idle();
    chk("pre_reset_valid", l2_response_valid, 1'b1);
    chk("pre_reset_stall", l2u_stall, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_valid", l2_response_valid, 1'b0);
    chk("async_reset_stall", l2u_stall, 1'b0);
    chk("async_reset_overflow", l2u_overflow, 1'b0);
    #1 reset = 1'b0;
    drive(L2REQ_LOAD, 4'd13, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    chk("post_reset_valid", l2_response_valid, 1'b1);
    chk("post_reset_id", l2_response.id, 4'd13);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
